// File: rtl/wait_state_mem_if.sv
// ============================================================================
// Module      : wait_state_mem_if
// Description : Request/response bundle for the wait-state memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wait_state_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/wait_state_mem.sv
// ============================================================================
// Module      : wait_state_mem
// Description : Cycle-accurate memory model with valid/ready requests, a
//               programmable wait-state counter and per-byte write strobes.
//               Optional macro WSMEM_RANGE_CHECK_EN flags out-of-range indices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_state_mem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  wait_state_mem_if.slave bus
);

  localparam int c_BYTES  = DATA_W / 8;
  localparam int c_OFF_W  = $clog2(c_BYTES);
  localparam int c_IDX_W  = $clog2(DEPTH);
  localparam int c_WIDX_W = ADDR_W - c_OFF_W;

  localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;

  logic                r_we;
  logic [c_WIDX_W-1:0] r_widx;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_BYTES-1:0]  r_be;
  logic [DATA_W-1:0]   r_rdata;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_enter_resp;
  logic                w_in_wait;
  logic                w_oob;
  logic                w_commit;
  logic [c_WIDX_W-1:0] w_req_widx;
  logic                w_acc_we;
  logic [c_WIDX_W-1:0] w_acc_idx;
  logic [c_IDX_W-1:0]  w_acc_midx;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic [c_BYTES-1:0]  w_acc_be;

  assign w_in_wait  = (r_state == c_ST_WAIT);
  assign w_accept   = bus.req_valid && bus.req_ready;
  assign w_req_widx = c_WIDX_W'(bus.req_addr >> c_OFF_W);

  // With no wait states the access happens on the accepting edge itself, so it
  // must use the live request; otherwise it uses the captured copy.
  assign w_enter_resp = (w_in_wait && (r_cnt == 4'd0)) || (w_accept && (WAIT_CYCLES == 0));
  assign w_acc_we     = w_in_wait ? r_we    : bus.req_we;
  assign w_acc_idx    = w_in_wait ? r_widx  : w_req_widx;
  assign w_acc_wdata  = w_in_wait ? r_wdata : bus.req_wdata;
  assign w_acc_be     = w_in_wait ? r_be    : bus.req_be;
  assign w_acc_midx   = w_acc_idx[c_IDX_W-1:0];
  assign w_commit     = w_enter_resp && w_acc_we && !w_oob;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = c_ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = c_ST_RESP;
          end else begin
            w_state_nxt = c_ST_WAIT;
            w_cnt_nxt   = c_WAIT_LOAD;
          end
        end else begin
          w_state_nxt = c_ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_widx  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_widx  <= w_req_widx;
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_acc_we || w_oob) ? '0 : r_mem[w_acc_midx];
      end
    end
  end

  // The array is deliberately left out of reset so preloaded contents survive.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < c_BYTES; b++) begin
        if (w_acc_be[b]) begin
          r_mem[w_acc_midx][b*8 +: 8] <= w_acc_wdata[b*8 +: 8];
        end
      end
    end
  end

`ifdef WSMEM_RANGE_CHECK_EN
  logic r_err;

  assign w_oob = (w_acc_idx >> c_IDX_W) != '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_enter_resp) begin
      r_err <= w_oob;
    end
  end

  assign bus.rsp_err = r_err;
`else
  logic w_unused_hi;

  assign w_oob       = 1'b0;
  assign w_unused_hi = ^w_acc_idx[c_WIDX_W-1:c_IDX_W];
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = !w_in_wait;
  assign bus.busy      = w_in_wait;
  assign bus.rsp_valid = (r_state == c_ST_RESP);
  assign bus.rsp_rdata = r_rdata;

endmodule

`default_nettype wire

// File: doc/wait_state_mem.md
# wait_state_mem

Parametrised, cycle-accurate memory model with a valid/ready request channel, a configurable wait-state counter and per-byte write strobes. It replaces the fixed single-cycle instruction/data memories in the CPU bench. It lets the pipeline's stall and forwarding paths run against multi-cycle memory latency. One instance serves the instruction port and one serves the data port.

## Interface
Parameters:
- `DATA_W`, 32: data width in bits; must be a multiple of 8.
- `ADDR_W`, 32: byte-address width.
- `DEPTH`, 1024: number of `DATA_W` words; must be a power of two.
- `WAIT_CYCLES`, 0: extra cycles between acceptance and access; range 0–15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request this cycle.
- `req_we`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  DATA_W: write data.
- `req_be`  in  DATA_W/8: byte write strobes; ignored on reads.
- `rsp_valid`  out  1: one-cycle pulse marking completion.
- `rsp_rdata`  out  DATA_W: read data; 0 for write responses.
- `rsp_err`  out  1: access error, valid with `rsp_valid`.
- `busy`  out  1: high while in WAIT.

## Operation
- Word index is `req_addr >> log2(DATA_W/8)`. Low byte-offset bits are ignored, so there is no misalignment fault.
- A request is accepted at the edge where `req_valid && req_ready`. At that edge `we`, the word index, `wdata` and `be` are captured into holding registers. Later input changes have no effect on the captured request.
- State machine:
  - IDLE → RESP on accept when `WAIT_CYCLES==0`.
  - IDLE → WAIT on accept when `WAIT_CYCLES>0`; the counter loads `WAIT_CYCLES-1`.
  - WAIT: the counter decrements each cycle. At 0 the next edge goes to RESP.
  - RESP: `rsp_valid=1` for this single cycle. An accept in RESP re-enters RESP or WAIT by the same rules as IDLE; otherwise RESP → IDLE.
- `req_ready = (state != WAIT)`. Back-to-back accepts are therefore legal from IDLE and RESP.
- The access is performed on the edge that enters RESP:
  - A write updates only the bytes whose `be` bit is 1.
  - A read registers the array word into `rsp_rdata`.
- Read-after-write ordering: a read accepted in the RESP cycle of a write returns the newly written data.
- The array is not cleared by reset. Contents are X until written or loaded with `$readmemb`.
- Without the error feature, index bits at and above `log2(DEPTH)` are discarded (wrap-around).

## Timing
- Latency from the accepting edge to the first cycle of `rsp_valid` is `WAIT_CYCLES+1` clocks.
- Throughput is one access per clock when `WAIT_CYCLES==0`, otherwise one per `WAIT_CYCLES+1` clocks.
- `rsp_rdata` and `rsp_err` hold their values until the next response. They are meaningful only while `rsp_valid` is high.
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `busy=0`, counter 0.
- Reset asserted mid-operation: the pending request is dropped. A write that has not yet reached its RESP edge is never committed.
- `req_valid` with `req_ready=0` is ignored. The requester must hold the request until it is accepted.

## Configuration
- `WSMEM_RANGE_CHECK_EN` defined:
  - A captured index `>= DEPTH` sets `rsp_err=1` in its RESP cycle.
  - An out-of-range write is suppressed and leaves the array unchanged.
  - An out-of-range read returns `rsp_rdata=0`.
- Macro undefined: the index wraps modulo `DEPTH`, and `rsp_err` is tied to 0.

## Test plan
- Reset release, `WAIT_CYCLES=0`: write 0xDEADBEEF to addr 0x10 with `be=4'hF`, then read addr 0x10 in the next cycle. Required: `rsp_valid` on two consecutive cycles, and the read returns 0xDEADBEEF.
- `WAIT_CYCLES=3`: read accepted at cycle 5. Required: `req_ready=0` and `busy=1` in cycles 6–8, `rsp_valid` in cycle 9, and `req_ready=1` again in cycle 9.
- Byte strobes: write 0x11223344, then write 0xAABBCCDD with `be=4'b0101`, then read. Required read data 0x11BB33DD.
- Reset mid-operation: with `WAIT_CYCLES=2`, accept a write of 0x55 to addr 0x20 and assert `rst` one cycle later. After release, a read of 0x20 must not return 0x55, and no `rsp_valid` pulse is seen during or after the reset.
- `DEPTH=16` at `DATA_W=32`:
  - Without the macro, a write to addr 0x40 followed by a read of addr 0x0 returns the written data (wrap).
  - With `WSMEM_RANGE_CHECK_EN`, the same write gives `rsp_err=1`, the read of 0x0 is unchanged, and a read of 0x40 gives `rsp_rdata=0` with `rsp_err=1`.
- Stress: 200 random back-to-back requests at `WAIT_CYCLES` of 0 and 2, checked against a reference array model. Required: zero mismatches, and exactly one `rsp_valid` per accepted request, in order.
